ddr_line_packer: RTL and testbench

Byte-to-line bridge between the SPART-side byte driver and the `ddr_sdr` controller user interface. It packs 16 upstream bytes into one 128-bit line and issues a WRITE to a self-incrementing line pointer. On a read request it issues a READ, captures the 128-bit result and streams the 16 bytes back out. It replaces per-byte DRAM access with line-granular bursts.

---
 rtl/ddr_line_packer_if.sv | 23 ++
 rtl/ddr_line_packer.sv | 127 ++++++++++++
 tb/tb_ddr_line_packer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_line_packer_if.sv
// rtl/ddr_line_packer_if.sv - controller-side command/data bus between ddr_line_packer and ddr_sdr
interface ddr_line_packer_if #(
  parameter int ADDR_W = 28
);
  logic [1:0]        mem_cmd;
  logic              mem_cmd_vld;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_busy;
  logic [127:0]      mem_data_in;
  logic              mem_data_req;
  logic [127:0]      mem_data_out;
  logic              mem_data_vld;

  modport master (
    output mem_cmd, mem_cmd_vld, mem_addr, mem_data_in,
    input  mem_busy, mem_data_req, mem_data_out, mem_data_vld
  );

  modport slave (
    input  mem_cmd, mem_cmd_vld, mem_addr, mem_data_in,
    output mem_busy, mem_data_req, mem_data_out, mem_data_vld
  );
endinterface

// File: rtl/ddr_line_packer.sv
// rtl/ddr_line_packer.sv - packs 16 bytes into 128-bit DDR line writes and streams line reads back as bytes
// Optional partial-line flush enabled by defining DDR_LINE_PACKER_FLUSH_EN.
module ddr_line_packer #(
  parameter int ADDR_W    = 28,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_STEP = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [7:0]        out_data,
  output logic              out_vld,
  input  logic              out_rdy,
  input  logic              flush,
  output logic [4:0]        fill_cnt,
  ddr_line_packer_if.master mem
);

  typedef enum logic [2:0] {
    IDLE, WR_ISSUE, WR_DATA, RD_ISSUE, RD_WAIT, DRAIN
  } state_t;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [127:0]      rd_line;
  logic [3:0]        idx;
  logic              in_acc;
  logic              flush_go;
  logic              line_full;

  assign line_full = (fill_cnt == 5'd16);
  assign in_rdy    = (state == IDLE) && !rd_req && !line_full;
  assign in_acc    = in_rdy && in_vld;
  assign out_vld   = (state == DRAIN);
  assign out_data  = out_vld ? rd_line[{idx, 3'b000} +: 8] : 8'h00;

`ifdef DDR_LINE_PACKER_FLUSH_EN
  assign flush_go = flush && (fill_cnt != 5'd0) && !line_full;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign flush_go     = 1'b0;
`endif

  // Priority in IDLE: full line, then flush, then read request, then byte accept.
  always_comb begin
    state_nxt = state;
    rd_ack    = 1'b0;
    case (state)
      IDLE: begin
        if (line_full || flush_go) begin
          state_nxt = WR_ISSUE;
        end else if (rd_req) begin
          rd_ack    = 1'b1;
          state_nxt = RD_ISSUE;
        end else if (in_acc && fill_cnt == 5'd15) begin
          state_nxt = WR_ISSUE;
        end
      end
      WR_ISSUE: if (!mem.mem_busy) state_nxt = WR_DATA;
      WR_DATA:  if (mem.mem_data_req) state_nxt = IDLE;
      RD_ISSUE: if (!mem.mem_busy) state_nxt = RD_WAIT;
      RD_WAIT:  if (mem.mem_data_vld) state_nxt = DRAIN;
      DRAIN:    if (out_rdy && idx == 4'd15) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      fill_cnt        <= 5'd0;
      wr_ptr          <= ADDR_W'(BASE_ADDR);
      rd_addr_q       <= '0;
      rd_line         <= '0;
      idx             <= 4'd0;
      mem.mem_cmd     <= CMD_NOP;
      mem.mem_cmd_vld <= 1'b0;
      mem.mem_addr    <= '0;
      mem.mem_data_in <= '0;
    end else begin
      state           <= state_nxt;
      mem.mem_cmd     <= CMD_NOP;
      mem.mem_cmd_vld <= 1'b0;
      if (in_acc) begin
        mem.mem_data_in[{fill_cnt[3:0], 3'b000} +: 8] <= in_data;
        fill_cnt <= fill_cnt + 5'd1;
      end
      if (rd_ack) rd_addr_q <= rd_addr;
      case (state)
        WR_ISSUE: if (!mem.mem_busy) begin
          mem.mem_cmd     <= CMD_WRITE;
          mem.mem_cmd_vld <= 1'b1;
          mem.mem_addr    <= wr_ptr;
        end
        // Clearing the line here makes a later flush pad with zeros for free.
        WR_DATA: if (mem.mem_data_req) begin
          wr_ptr          <= wr_ptr + ADDR_W'(ADDR_STEP);
          fill_cnt        <= 5'd0;
          mem.mem_data_in <= '0;
        end
        RD_ISSUE: if (!mem.mem_busy) begin
          mem.mem_cmd     <= CMD_READ;
          mem.mem_cmd_vld <= 1'b1;
          mem.mem_addr    <= rd_addr_q;
        end
        RD_WAIT: if (mem.mem_data_vld) begin
          rd_line <= mem.mem_data_out;
          idx     <= 4'd0;
        end
        DRAIN: if (out_rdy) idx <= idx + 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_line_packer.sv
// tb/tb_ddr_line_packer.sv - directed self-checking bench for ddr_line_packer (follows DDR_LINE_PACKER_FLUSH_EN)
module tb_ddr_line_packer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_vld, in_rdy, in_rdy2;
  logic        rd_req, rd_ack, rd_ack2;
  logic [27:0] rd_addr;
  logic [7:0]  out_data, out_data2;
  logic        out_vld, out_vld2, out_rdy;
  logic        flush;
  logic [4:0]  fill_cnt, fill_cnt2;

  int tests = 0;
  int fails = 0;
  int cmd_cnt = 0;

  ddr_line_packer_if #(.ADDR_W(28)) m1 ();
  ddr_line_packer_if #(.ADDR_W(4))  m2 ();

  assign m2.mem_busy     = m1.mem_busy;
  assign m2.mem_data_req = m1.mem_data_req;
  assign m2.mem_data_out = m1.mem_data_out;
  assign m2.mem_data_vld = m1.mem_data_vld;

  ddr_line_packer #(.ADDR_W(28), .BASE_ADDR(0), .ADDR_STEP(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .out_data(out_data),
    .out_vld(out_vld), .out_rdy(out_rdy), .flush(flush), .fill_cnt(fill_cnt), .mem(m1)
  );

  ddr_line_packer #(.ADDR_W(4), .BASE_ADDR(14), .ADDR_STEP(2)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy2),
    .rd_req(rd_req), .rd_addr(rd_addr[3:0]), .rd_ack(rd_ack2), .out_data(out_data2),
    .out_vld(out_vld2), .out_rdy(out_rdy), .flush(flush), .fill_cnt(fill_cnt2), .mem(m2)
  );

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #1;
    if (m1.mem_cmd_vld === 1'b1) cmd_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data = b;
    in_vld  = 1'b1;
    #1;
    while (!in_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_rdy) check("in_rdy_wait", in_rdy, 1);
    @(negedge clk);
    in_vld = 1'b0;
  endtask

  task automatic wait_cmd(input string tag);
    int n = 0;
    while (m1.mem_cmd_vld !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_cmd_seen"}, m1.mem_cmd_vld, 1);
  endtask

  task automatic data_req_pulse();
    m1.mem_data_req = 1'b1;
    @(negedge clk);
    m1.mem_data_req = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_fill"},   fill_cnt, 0);
    check({tag, "_cmd"},    m1.mem_cmd, 0);
    check({tag, "_vld"},    m1.mem_cmd_vld, 0);
    check({tag, "_addr"},   m1.mem_addr, 0);
    check({tag, "_din"},    m1.mem_data_in, 0);
    check({tag, "_outvld"}, out_vld, 0);
    check({tag, "_outdat"}, out_data, 0);
    check({tag, "_rdack"},  rd_ack, 0);
  endtask

  initial begin
    int nb, cyc, base_cnt;
    logic prev_hold, bad;
    logic [7:0] prev_data;
    rst_n = 1'b0; in_data = 8'h00; in_vld = 1'b0; rd_req = 1'b0; rd_addr = '0;
    out_rdy = 1'b0; flush = 1'b0;
    m1.mem_busy = 1'b0; m1.mem_data_req = 1'b0; m1.mem_data_out = '0; m1.mem_data_vld = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Line write
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    check("wr_full_fill", fill_cnt, 16);
    check("wr_full_rdy", in_rdy, 0);
    check("wr_early_vld", m1.mem_cmd_vld, 0);
    @(negedge clk);
    check("wr_vld", m1.mem_cmd_vld, 1);
    check("wr_cmd", m1.mem_cmd, 2);
    check("wr_addr", m1.mem_addr, 0);
    check("wr_data", m1.mem_data_in, 128'h0F0E0D0C0B0A09080706050403020100);
    check("wrap_addr0", m2.mem_addr, 14);
    @(negedge clk);
    check("wr_vld_pulse", m1.mem_cmd_vld, 0);
    check("wr_cmd_nop", m1.mem_cmd, 0);
    data_req_pulse();
    check("wr_done_fill", fill_cnt, 0);
    check("wr_done_rdy", in_rdy, 1);
    check("wr_cmd_count", cmd_cnt, 1);

    // Busy stall
    m1.mem_busy = 1'b1;
    for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i));
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (m1.mem_cmd_vld || in_rdy) bad = 1'b1;
      @(negedge clk);
    end
    check("stall_quiet", bad, 0);
    m1.mem_busy = 1'b0;
    @(negedge clk);
    check("stall_vld", m1.mem_cmd_vld, 1);
    check("stall_addr", m1.mem_addr, 2);
    check("wrap_addr1", m2.mem_addr, 0);
    @(negedge clk);
    check("stall_pulse_once", cmd_cnt, 2);
    data_req_pulse();

    // Priority and line read
    for (int i = 0; i < 5; i++) send_byte(8'h20 + 8'(i));
    in_data = 8'h25; in_vld = 1'b1; rd_req = 1'b1; rd_addr = 28'h40;
    #1;
    check("prio_ack", rd_ack, 1);
    check("prio_rdy", in_rdy, 0);
    @(negedge clk);
    rd_req = 1'b0;
    check("ack_pulse", rd_ack, 0);
    @(negedge clk);
    check("rd_vld", m1.mem_cmd_vld, 1);
    check("rd_cmd", m1.mem_cmd, 1);
    check("rd_addr", m1.mem_addr, 28'h40);
    @(negedge clk);
    check("rd_wait_fill", fill_cnt, 5);
    check("rd_wait_outvld", out_vld, 0);
    m1.mem_data_out = 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0;
    m1.mem_data_vld = 1'b1;
    @(negedge clk);
    m1.mem_data_vld = 1'b0;
    check("drain_first", out_vld, 1);
    nb = 0; cyc = 0; prev_hold = 1'b0; prev_data = 8'h00;
    while (nb < 16 && cyc < 100) begin
      if (prev_hold) check("drain_hold", out_data, prev_data);
      out_rdy = ((cyc % 3) != 1);
      if (out_vld && out_rdy) begin
        check($sformatf("rd_byte%0d", nb), out_data, 8'hA0 + nb);
        nb++;
      end
      prev_hold = out_vld && !out_rdy;
      prev_data = out_data;
      @(negedge clk);
      cyc++;
    end
    out_rdy = 1'b0;
    check("drain_count", nb, 16);
    check("drain_end", out_vld, 0);
    check("drain_fill", fill_cnt, 5);
    @(negedge clk);
    in_vld = 1'b0;
    check("byte5_fill", fill_cnt, 6);
    check("byte5_data", m1.mem_data_in[47:40], 8'h25);

    // Complete the line, then exercise flush
    for (int i = 6; i < 16; i++) send_byte(8'h20 + 8'(i));
    wait_cmd("line3");
    check("line3_addr", m1.mem_addr, 4);
    @(negedge clk);
    data_req_pulse();
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    base_cnt = cmd_cnt;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
`ifdef DDR_LINE_PACKER_FLUSH_EN
    wait_cmd("flush");
    check("flush_addr", m1.mem_addr, 6);
    check("flush_data", m1.mem_data_in, 128'h00CCBBAA);
    @(negedge clk);
    data_req_pulse();
    check("flush_fill", fill_cnt, 0);
`else
    repeat (20) @(negedge clk);
    check("noflush_cmds", cmd_cnt, base_cnt);
    check("noflush_fill", fill_cnt, 3);
`endif

    // Reset during RD_WAIT
    rd_req = 1'b1; rd_addr = 28'h80;
    #1;
    check("rd2_ack", rd_ack, 1);
    @(negedge clk);
    rd_req = 1'b0;
    wait_cmd("rd2");
    check("rd2_addr", m1.mem_addr, 28'h80);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("midrst");
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) send_byte(8'h50 + 8'(i));
    wait_cmd("post_rst");
    check("post_rst_addr", m1.mem_addr, 0);
    check("post_rst_wrap", m2.mem_addr, 14);
    @(negedge clk);
    data_req_pulse();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
